serial_sub_ctrl: RTL

//  Bit-serial N-bit subtractor controller built around one 1-bit full-subtractor cell
//  (d = a^b^c, br = ~a&b | b&c | c&~a), instantiated internally.

---
 rtl/serial_sub_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial N-bit subtractor controller, optional ovf via SERIAL_SUB_OVF_EN

// Single-bit full-subtractor cell: d = a - b - c, br = borrow out.
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic br
);
  assign d  = a ^ b ^ c;
  assign br = (~a & b) | (b & c) | (c & ~a);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sa, sb, work;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_br;

  serial_sub_cell u_cell (
    .a  (sa[0]),
    .b  (sb[0]),
    .c  (brw),
    .d  (cell_d),
    .br (cell_br)
  );

  assign last_bit = (state == S_SHIFT) && (cnt == LAST);
  assign busy     = (state == S_SHIFT);
  assign done     = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured outside SHIFT.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SHIFT;
          accept    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_SHIFT;
          accept    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, LSB-first shift datapath and result capture on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      work <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      brw <= bin;
      cnt <= '0;
    end else if (state == S_SHIFT) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      brw  <= cell_br;
      work <= {cell_d, work[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        diff <= {cell_d, work[WIDTH-1:1]};
        bout <= cell_br;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;

  // Operand sign bits are kept since the shift regs lose them; ovf updates with diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last_bit) begin
      ovf <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end
`endif

endmodule
